// File: rtl/prog_timer_if.sv
// Control and status bundle for prog_timer: commands toward the timer,
// count/status back to the controller.
interface prog_timer_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic             stop;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             mode;
    logic [WIDTH-1:0] timer;
    logic             running;
    logic             expired;

    modport master (
        output start, stop, clear, load, load_value, mode,
        input  timer, running, expired
    );

    modport slave (
        input  start, stop, clear, load, load_value, mode,
        output timer, running, expired
    );
endinterface

// File: rtl/prog_timer.sv
// Programmable up/down tick timer with prescaler, optional auto-reload in
// down mode and a registered one-cycle expiry pulse.
module prog_timer #(
    parameter int TICK_DIV = 1000000,
    parameter int WIDTH    = 4,
    parameter bit RELOAD   = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    prog_timer_if.slave bus
);
    localparam int              PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PRE_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [PW-1:0]    pre_reg, pre_next;
    logic [WIDTH-1:0] timer_reg, timer_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             mode_reg, mode_next;
    logic             expired_reg, expired_next;
    logic             tick;

    assign tick = (state_reg == RUN) && (pre_reg == PRE_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            pre_reg     <= '0;
            timer_reg   <= '0;
            reload_reg  <= '0;
            mode_reg    <= 1'b0;
            expired_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pre_reg     <= pre_next;
            timer_reg   <= timer_next;
            reload_reg  <= reload_next;
            mode_reg    <= mode_next;
            expired_reg <= expired_next;
        end
    end

    // Control actions form one priority chain; any of them pre-empts a tick.
    always_comb begin
        state_next   = state_reg;
        pre_next     = pre_reg;
        timer_next   = timer_reg;
        reload_next  = reload_reg;
        mode_next    = mode_reg;
        expired_next = 1'b0;
        if (bus.clear) begin
            timer_next = '0;
            pre_next   = '0;
            state_next = IDLE;
        end else if (bus.load) begin
            timer_next  = bus.load_value;
            reload_next = bus.load_value;
            pre_next    = '0;
            state_next  = IDLE;
        end else if (bus.stop) begin
            if (state_reg == RUN) begin
                state_next = IDLE;
            end
        end else if (bus.start && (state_reg != RUN)) begin
            // A down count from zero has nothing to do, so it never starts.
            if (!(bus.mode && (timer_reg == '0))) begin
                mode_next  = bus.mode;
                state_next = RUN;
            end
        end else if (state_reg == RUN) begin
            if (tick) begin
                pre_next = '0;
                if (!mode_reg) begin
                    timer_next   = timer_reg + CNT_ONE;
                    expired_next = (timer_reg == CNT_MAX);
                end else if (timer_reg > CNT_ONE) begin
                    timer_next = timer_reg - CNT_ONE;
                end else begin
                    expired_next = 1'b1;
                    if (RELOAD && (reload_reg != '0)) begin
                        timer_next = reload_reg;
                    end else begin
                        timer_next = '0;
                        state_next = DONE;
                    end
                end
            end else begin
                pre_next = pre_reg + PRE_ONE;
            end
        end
    end

    assign bus.timer   = timer_reg;
    assign bus.running = (state_reg == RUN);
    assign bus.expired = expired_reg;
endmodule

// File: tb/tb_prog_timer.sv
// Bench for prog_timer: one instance without and one with auto-reload, both
// driven identically and compared every cycle against a behavioural model.
module tb_prog_timer;
    localparam int TD = 4;
    localparam int W  = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    prog_timer_if #(.WIDTH(W)) if0 ();
    prog_timer_if #(.WIDTH(W)) if1 ();

    prog_timer #(.TICK_DIV(TD), .WIDTH(W), .RELOAD(1'b0)) dut0 (
        .clock(clock), .reset(reset), .bus(if0)
    );
    prog_timer #(.TICK_DIV(TD), .WIDTH(W), .RELOAD(1'b1)) dut1 (
        .clock(clock), .reset(reset), .bus(if1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // currently applied controls
    bit c_st, c_sp, c_cl, c_ld, c_md;
    int c_lv;

    // reference model, index = RELOAD setting of the instance
    int m_cnt[2], m_pre[2], m_rel[2], m_dir[2], m_st[2];
    bit m_exp[2];

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 2; r++) begin
            m_cnt[r] = 0; m_pre[r] = 0; m_rel[r] = 0;
            m_dir[r] = 0; m_st[r] = M_IDLE; m_exp[r] = 1'b0;
        end
    endfunction

    function automatic void model_step(int r);
        m_exp[r] = 1'b0;
        if (c_cl) begin
            m_cnt[r] = 0; m_pre[r] = 0; m_st[r] = M_IDLE;
        end else if (c_ld) begin
            m_cnt[r] = c_lv; m_rel[r] = c_lv; m_pre[r] = 0; m_st[r] = M_IDLE;
        end else if (c_sp) begin
            if (m_st[r] == M_RUN) m_st[r] = M_IDLE;
        end else if (c_st && m_st[r] != M_RUN) begin
            if (!(c_md && m_cnt[r] == 0)) begin
                m_dir[r] = c_md; m_st[r] = M_RUN;
            end
        end else if (m_st[r] == M_RUN) begin
            m_pre[r] = (m_pre[r] + 1) % TD;
            if (m_pre[r] == 0) begin
                if (m_dir[r] == 0) begin
                    m_cnt[r] = (m_cnt[r] + 1) % (1 << W);
                    m_exp[r] = (m_cnt[r] == 0);
                end else if (m_cnt[r] > 1) begin
                    m_cnt[r] = m_cnt[r] - 1;
                end else begin
                    m_exp[r] = 1'b1;
                    if (r == 1 && m_rel[r] != 0) m_cnt[r] = m_rel[r];
                    else begin m_cnt[r] = 0; m_st[r] = M_DONE; end
                end
            end
        end
    endfunction

    task automatic set_in(bit st, bit sp, bit cl, bit ld, int lv, bit md);
        c_st = st; c_sp = sp; c_cl = cl; c_ld = ld; c_lv = lv; c_md = md;
        if0.start = st; if0.stop = sp; if0.clear = cl; if0.load = ld;
        if0.load_value = W'(lv); if0.mode = md;
        if1.start = st; if1.stop = sp; if1.clear = cl; if1.load = ld;
        if1.load_value = W'(lv); if1.mode = md;
    endtask

    task automatic cmp_model(string tag);
        check({tag, " timer0"},   int'(if0.timer),   m_cnt[0]);
        check({tag, " running0"}, int'(if0.running), int'(m_st[0] == M_RUN));
        check({tag, " expired0"}, int'(if0.expired), int'(m_exp[0]));
        check({tag, " timer1"},   int'(if1.timer),   m_cnt[1]);
        check({tag, " running1"}, int'(if1.running), int'(m_st[1] == M_RUN));
        check({tag, " expired1"}, int'(if1.expired), int'(m_exp[1]));
    endtask

    task automatic step(string tag);
        @(posedge clock);
        model_step(0);
        model_step(1);
        #1;
        cmp_model(tag);
    endtask

    task automatic pulse(bit st, bit sp, bit cl, bit ld, int lv, bit md, string tag);
        set_in(st, sp, cl, ld, lv, md);
        step(tag);
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(int n, string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    typedef struct {
        bit st, sp, cl, ld;
        int lv;
        bit md;
        int cyc;
        int exp_timer;
        bit exp_run;
    } vec_t;

    vec_t tbl[10];
    int   n_exp;

    initial begin
        set_in(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        model_reset();
        #12;
        check("reset timer0",   int'(if0.timer),   0);
        check("reset running0", int'(if0.running), 0);
        check("reset expired0", int'(if0.expired), 0);
        check("reset timer1",   int'(if1.timer),   0);
        @(negedge clock);
        reset = 1'b1;
        idle(2, "post-reset");
        $display("reset released: timer=%0d running=%0d", if0.timer, if0.running);

        //            st sp cl ld lv md cyc timer run
        tbl[0] = '{0, 0, 0, 1, 5, 0, 1, 5, 0};
        tbl[1] = '{1, 0, 0, 0, 0, 0, 1, 5, 1};
        tbl[2] = '{0, 0, 0, 0, 0, 0, 4, 6, 1};
        tbl[3] = '{0, 1, 0, 0, 0, 0, 1, 6, 0};
        tbl[4] = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
        tbl[5] = '{1, 0, 0, 0, 0, 1, 1, 0, 0};
        tbl[6] = '{1, 0, 0, 1, 9, 1, 1, 9, 0};
        tbl[7] = '{1, 0, 0, 0, 0, 1, 1, 9, 1};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 8, 7, 1};
        tbl[9] = '{1, 0, 0, 0, 0, 0, 4, 6, 1};
        for (int v = 0; v < 10; v++) begin
            set_in(tbl[v].st, tbl[v].sp, tbl[v].cl, tbl[v].ld, tbl[v].lv, tbl[v].md);
            idle(tbl[v].cyc, $sformatf("vec%0d", v));
            check($sformatf("vec%0d table timer0", v), int'(if0.timer), tbl[v].exp_timer);
            check($sformatf("vec%0d table running0", v), int'(if0.running), int'(tbl[v].exp_run));
            check($sformatf("vec%0d table timer1", v), int'(if1.timer), tbl[v].exp_timer);
            $display("vec %0d: timer=%0d running=%0d", v, if0.timer, if0.running);
        end
        set_in(0, 0, 0, 0, 0, 0);

        // up count through wrap
        pulse(0, 0, 1, 0, 0, 0, "up clear");
        pulse(1, 0, 0, 0, 0, 0, "up start");
        for (int k = 1; k <= 64; k++) begin
            step("up run");
            if (k == 60) check("up timer at 60", int'(if0.timer), 15);
            if (k == 63) check("up no early expired", int'(if0.expired), 0);
        end
        check("up wrap timer", int'(if0.timer), 0);
        check("up wrap expired", int'(if0.expired), 1);
        step("up after wrap");
        check("up expired one cycle", int'(if0.expired), 0);
        check("up still running", int'(if0.running), 1);
        $display("up wrap: timer=%0d running=%0d", if0.timer, if0.running);

        // down to zero without reload, with reload on instance 1
        pulse(0, 0, 0, 1, 3, 0, "down load");
        pulse(1, 0, 0, 0, 0, 1, "down start");
        n_exp = 0;
        for (int k = 1; k <= 13; k++) begin
            step("down run");
            n_exp += int'(if0.expired);
            if (k == 4)  check("down tick1", int'(if0.timer), 2);
            if (k == 8)  check("down tick2", int'(if0.timer), 1);
            if (k == 12) begin
                check("down tick3", int'(if0.timer), 0);
                check("down done running", int'(if0.running), 0);
                check("down reload timer1", int'(if1.timer), 3);
            end
        end
        check("down expired count", n_exp, 1);
        pulse(1, 0, 0, 0, 0, 1, "down restart");
        check("down restart ignored", int'(if0.running), 0);
        $display("down: timer=%0d running=%0d", if0.timer, if0.running);

        // auto-reload period of two ticks
        pulse(0, 0, 0, 1, 2, 0, "reload load");
        pulse(1, 0, 0, 0, 0, 1, "reload start");
        for (int k = 1; k <= 16; k++) begin
            step("reload run");
            if (k % 4 == 0) begin
                check($sformatf("reload timer t%0d", k / 4), int'(if1.timer), ((k / 4) % 2 == 1) ? 1 : 2);
                check($sformatf("reload expired t%0d", k / 4), int'(if1.expired), ((k / 4) % 2 == 0) ? 1 : 0);
            end
        end
        $display("reload: timer=%0d running=%0d", if1.timer, if1.running);

        // pause and resume keep the prescaler phase
        pulse(0, 0, 1, 0, 0, 0, "pause clear");
        pulse(1, 0, 0, 0, 0, 0, "pause start");
        idle(4, "pause first tick");
        check("pause first tick", int'(if0.timer), 1);
        idle(2, "pause gap");
        pulse(0, 1, 0, 0, 0, 0, "pause stop");
        check("pause stopped", int'(if0.running), 0);
        idle(10, "pause hold");
        check("pause frozen", int'(if0.timer), 1);
        pulse(1, 0, 0, 0, 0, 0, "pause resume");
        step("pause r1");
        check("pause no tick yet", int'(if0.timer), 1);
        step("pause r2");
        check("pause tick after resume", int'(if0.timer), 2);
        pulse(1, 0, 1, 0, 0, 0, "clear+start");
        check("clear+start timer", int'(if0.timer), 0);
        check("clear+start running", int'(if0.running), 0);
        $display("pause/resume: timer=%0d running=%0d", if0.timer, if0.running);

        // asynchronous reset between edges while running
        pulse(1, 0, 0, 0, 0, 0, "areset start");
        idle(5, "areset run");
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check("areset timer0",   int'(if0.timer),   0);
        check("areset running0", int'(if0.running), 0);
        check("areset expired0", int'(if0.expired), 0);
        check("areset running1", int'(if1.running), 0);
        @(negedge clock);
        reset = 1'b1;
        idle(3, "areset after");
        $display("async reset: timer=%0d running=%0d", if0.timer, if0.running);

        // randomized control traffic
        for (int b = 0; b < 30; b++) begin
            for (int i = 0; i < 100; i++) begin
                set_in($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4,
                       $urandom_range(0, 99) < 2,  $urandom_range(0, 99) < 3,
                       int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
                step("random");
            end
            $display("random batch %0d: timer0=%0d timer1=%0d", b, if0.timer, if1.timer);
        end
        set_in(0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prog_timer.md
PROG_TIMER -- requirements
Module: prog_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, clock cycles per count tick (>=2).
REQ-002 SHALL have parameter WIDTH, default 4, count width in bits (1..32).
REQ-003 SHALL have parameter RELOAD, default 0; 1 enables auto-reload in down mode.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  begin or resume counting.
REQ-007 SHALL have port stop  input  1  pause counting.
REQ-008 SHALL have port clear  input  1  zero count and prescaler, return to IDLE.
REQ-009 SHALL have port load  input  1  write load_value to count and reload register, go IDLE.
REQ-010 SHALL have port load_value  input  WIDTH  value captured by load.
REQ-011 SHALL have port mode  input  1  0 = count up, 1 = count down; sampled only on start.
REQ-012 SHALL have port timer  output  WIDTH  current count.
REQ-013 SHALL have port running  output  1  high exactly while in RUN.
REQ-014 SHALL have port expired  output  1  registered one-cycle event pulse.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; running = (state == RUN).
REQ-016 SHALL apply per-cycle control priority clear > load > stop > start.
REQ-017 clear SHALL set timer = 0, prescaler = 0, state = IDLE, from any state.
REQ-018 load SHALL set timer = load_value, reload register = load_value, prescaler = 0, state = IDLE.
REQ-019 stop in RUN SHALL go to IDLE, holding timer and prescaler unchanged (pause); stop elsewhere SHALL have no effect.
REQ-020 start in IDLE or DONE SHALL latch mode and enter RUN, keeping the prescaler value; start in RUN SHALL have no effect.
REQ-021 start with mode = 1 and timer = 0 SHALL be ignored (state unchanged, no expired).
REQ-022 In RUN, the prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; a tick SHALL occur on the cycle the prescaler equals TICK_DIV-1.
REQ-023 The prescaler SHALL be $clog2(TICK_DIV) bits wide and SHALL hold outside RUN.
REQ-024 Up-mode tick SHALL set timer = timer + 1 modulo 2^WIDTH; on wrap from 2^WIDTH-1 to 0, expired SHALL pulse and RUN continues.
REQ-025 Down-mode tick with timer > 1 SHALL decrement timer.
REQ-026 Down-mode tick with timer = 1 and RELOAD = 0 SHALL set timer = 0, state = DONE, and pulse expired.
REQ-027 Down-mode tick with timer = 1, RELOAD = 1 and reload register != 0 SHALL set timer = reload register, stay in RUN, and pulse expired; period = reload-register ticks.
REQ-028 Down-mode tick with timer = 1, RELOAD = 1 and reload register = 0 SHALL behave as REQ-026.
REQ-029 expired SHALL be high for exactly the one cycle following the edge on which the triggering tick is applied, and low otherwise.
REQ-030 A tick coinciding with clear, load or stop SHALL be discarded; the control action wins.
REQ-031 Changes to mode while in RUN SHALL be ignored.

Reset
REQ-032 reset low SHALL immediately, without waiting for a clock edge, force timer = 0, prescaler = 0, reload register = 0, latched mode = 0, state = IDLE, running = 0 and expired = 0.
REQ-033 Release of reset SHALL be followed by normal operation from the next rising clock edge; reset asserted mid-RUN SHALL abort with no expired pulse.

Verification (TICK_DIV = 4, WIDTH = 4)
REQ-034 Bench SHALL run reset low, then high -> timer = 0, running = 0, expired = 0.
REQ-035 Bench SHALL run start, mode = 0 -> timer increments every 4 cycles, reaches 15 after 60 cycles, and wraps to 0 at cycle 64 with a one-cycle expired pulse; running stays 1.
REQ-036 Bench SHALL run RELOAD = 0: load 3, then start with mode = 1 -> timer 2, 1, 0 at ticks 1, 2, 3; expired pulses once; state DONE, running = 0; a further start is ignored.
REQ-037 Bench SHALL run RELOAD = 1: load 2, then start with mode = 1 -> sequence 2, 1, 2, 1, ... with expired pulsing every 2 ticks.
REQ-038 Bench SHALL run stop two cycles after a tick, wait 10 cycles, then start -> timer frozen while stopped, next tick 2 cycles after restart; clear and start in the same cycle -> timer = 0, IDLE.
REQ-039 Bench SHALL assert reset asynchronously mid-RUN between clock edges -> outputs zero immediately, no expired pulse.
